// File: rtl/i2c_slave_regmap.sv
// I2C target with a byte-wide register-map port, fully synchronous to clk.
// SCL/SDA are sampled as data, glitch-filtered, and decoded by one FSM.
`timescale 1ns/1ps
module i2c_slave_regmap #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5A,
  parameter int         FILTER_LEN = 3,
  parameter bit         AUTO_INC   = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       reg_re,
  output logic       busy
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ACK_ADDR  = 4'd2;
  localparam logic [3:0] WR_PTR    = 4'd3;
  localparam logic [3:0] ACK_PTR   = 4'd4;
  localparam logic [3:0] WR_DATA   = 4'd5;
  localparam logic [3:0] ACK_WR    = 4'd6;
  localparam logic [3:0] RD_DATA   = 4'd7;
  localparam logic [3:0] RD_ACK    = 4'd8;
  localparam logic [3:0] WAIT_STOP = 4'd9;

  logic [1:0] raw_in;
  logic [1:0] filt;
  assign raw_in = {sda_in, scl_in};

  // Index 0 = SCL, 1 = SDA: synchroniser then a stable-count filter.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cond
      logic       sync1_reg;
      logic       sync2_reg;
      logic       filt_reg;
      logic [2:0] cnt_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= 3'd0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= 3'd0;
          end else if (cnt_reg == 3'(FILTER_LEN - 1)) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= 3'd0;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  logic scl_q_reg, sda_q_reg;
  logic scl_f, sda_f;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_f = filt[0];
  assign sda_f = filt[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_q_reg <= 1'b1;
      sda_q_reg <= 1'b1;
    end else begin
      scl_q_reg <= scl_f;
      sda_q_reg <= sda_f;
    end
  end

  assign scl_rise   = scl_f & ~scl_q_reg;
  assign scl_fall   = ~scl_f & scl_q_reg;
  assign start_cond = scl_f & scl_q_reg & sda_q_reg & ~sda_f;
  assign stop_cond  = scl_f & scl_q_reg & ~sda_q_reg & sda_f;

  logic [3:0] state_reg;
  logic [3:0] cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic       we_reg, re_reg, oe_reg, busy_reg;
  logic       rw_reg, nack_reg, inc_reg;
  logic       shifting, bit_in, byte_done;

  assign shifting  = (state_reg == ADDR) || (state_reg == WR_PTR) || (state_reg == WR_DATA);
  assign bit_in    = scl_rise && (cnt_reg != 4'd8);
  assign byte_done = scl_fall && (cnt_reg == 4'd8);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      shift_reg <= 8'd0;
      addr_reg  <= 8'd0;
      wdata_reg <= 8'd0;
      we_reg    <= 1'b0;
      re_reg    <= 1'b0;
      oe_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      rw_reg    <= 1'b0;
      nack_reg  <= 1'b0;
      inc_reg   <= 1'b0;
    end else begin
      we_reg  <= 1'b0;
      re_reg  <= 1'b0;
      inc_reg <= 1'b0;
      // Pointer bump lands one clk after the strobe that consumed it.
      if (inc_reg) addr_reg <= addr_reg + 8'd1;

      if (stop_cond) begin
        state_reg <= IDLE;
        oe_reg    <= 1'b0;
        busy_reg  <= 1'b0;
        cnt_reg   <= 4'd0;
      end else if (start_cond) begin
        state_reg <= ADDR;
        oe_reg    <= 1'b0;
        cnt_reg   <= 4'd0;
      end else begin
        if (shifting && bit_in) begin
          shift_reg <= {shift_reg[6:0], sda_f};
          cnt_reg   <= cnt_reg + 4'd1;
        end
        case (state_reg)
          ADDR: begin
            if (byte_done) begin
              cnt_reg <= 4'd0;
              if (shift_reg[7:1] == SLAVE_ADDR) begin
                state_reg <= ACK_ADDR;
                oe_reg    <= 1'b1;
                busy_reg  <= 1'b1;
                rw_reg    <= shift_reg[0];
              end else begin
                state_reg <= IDLE;
              end
            end
          end
          WR_PTR: begin
            if (byte_done) begin
              cnt_reg   <= 4'd0;
              addr_reg  <= shift_reg;
              oe_reg    <= 1'b1;
              state_reg <= ACK_PTR;
            end
          end
          WR_DATA: begin
            if (byte_done) begin
              cnt_reg   <= 4'd0;
              wdata_reg <= shift_reg;
              we_reg    <= 1'b1;
              oe_reg    <= 1'b1;
              inc_reg   <= AUTO_INC;
              state_reg <= ACK_WR;
            end
          end
          ACK_PTR, ACK_WR: begin
            if (scl_fall) begin
              oe_reg    <= 1'b0;
              cnt_reg   <= 4'd0;
              state_reg <= WR_DATA;
            end
          end
          ACK_ADDR: begin
            if (scl_fall) begin
              cnt_reg <= 4'd0;
              if (rw_reg) begin
                shift_reg <= reg_rdata;
                re_reg    <= 1'b1;
                oe_reg    <= ~reg_rdata[7];
                inc_reg   <= AUTO_INC;
                state_reg <= RD_DATA;
              end else begin
                oe_reg    <= 1'b0;
                state_reg <= WR_PTR;
              end
            end
          end
          RD_DATA: begin
            // cnt_reg counts bits already driven after bit 7.
            if (scl_fall) begin
              if (cnt_reg == 4'd7) begin
                oe_reg    <= 1'b0;
                cnt_reg   <= 4'd0;
                state_reg <= RD_ACK;
              end else begin
                oe_reg    <= ~shift_reg[6];
                shift_reg <= {shift_reg[6:0], 1'b0};
                cnt_reg   <= cnt_reg + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              nack_reg <= sda_f;
              cnt_reg  <= 4'd1;
            end else if (scl_fall && cnt_reg == 4'd1) begin
              cnt_reg <= 4'd0;
              if (!nack_reg) begin
                shift_reg <= reg_rdata;
                re_reg    <= 1'b1;
                oe_reg    <= ~reg_rdata[7];
                inc_reg   <= AUTO_INC;
                state_reg <= RD_DATA;
              end else begin
                oe_reg    <= 1'b0;
                busy_reg  <= 1'b0;
                state_reg <= WAIT_STOP;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda_oe    = oe_reg;
  assign reg_addr  = addr_reg;
  assign reg_wdata = wdata_reg;
  assign reg_we    = we_reg;
  assign reg_re    = re_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Bench for i2c_slave_regmap: two targets share one bus, a bit-level master
// drives it and a transaction-level model predicts strobes, ACKs and data.
`timescale 1ns/1ps
module tb_i2c_slave_regmap;
  localparam int T_Q = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1, sda_bus;
  logic oe_a, oe_b, we_a, we_b, re_a, re_b, busy_a, busy_b;
  logic [7:0] addr_a, addr_b, wd_a, wd_b, rd_a, rd_b;
  logic [7:0] regs_a [256];
  logic [7:0] regs_b [256];

  logic [7:0] mdl [2][256];
  int ptr [2];
  bit ainc [2] = '{1'b1, 1'b0};
  int exp_wa [$], exp_wb [$], exp_ra [$], exp_rb [$];
  logic [7:0] rdq [$];
  int cur = -1;
  int ack_cnt = 0;
  int checks = 0, errors = 0;
  bit allow_a = 1'b0, allow_b = 1'b0, clear_allow = 1'b0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~oe_a & ~oe_b;
  assign rd_a = regs_a[addr_a];
  assign rd_b = regs_b[addr_b];

  i2c_slave_regmap #(.SLAVE_ADDR(7'h5A), .FILTER_LEN(3), .AUTO_INC(1'b1)) u_dut_a (
    .clk(clk), .rstn(rstn), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(oe_a),
    .reg_addr(addr_a), .reg_wdata(wd_a), .reg_we(we_a), .reg_rdata(rd_a),
    .reg_re(re_a), .busy(busy_a));

  i2c_slave_regmap #(.SLAVE_ADDR(7'h3C), .FILTER_LEN(3), .AUTO_INC(1'b0)) u_dut_b (
    .clk(clk), .rstn(rstn), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(oe_b),
    .reg_addr(addr_b), .reg_wdata(wd_b), .reg_we(we_b), .reg_rdata(rd_b),
    .reg_re(re_b), .busy(busy_b));

  function automatic logic [7:0] init_val(input int i, input int id);
    if (id == 0 && i == 32'h20) return 8'h5A;
    if (id == 0 && i == 32'h21) return 8'hC3;
    return 8'((i * 37 + 11 + id * 101) % 256);
  endfunction

  // Register files behind each target; reloaded with known contents in reset.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) begin
        regs_a[i] <= init_val(i, 0);
        regs_b[i] <= init_val(i, 1);
      end
    end else begin
      if (we_a) regs_a[addr_a] <= wd_a;
      if (we_b) regs_b[addr_b] <= wd_b;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic cmp_side(input int id, input logic we, input logic re, input logic oe,
                          input logic [7:0] addr, input logic [7:0] wd, input bit allow);
    int e;
    int qs;
    if (we || re) chk(id == 0 ? "we_re_excl_a" : "we_re_excl_b", int'(we & re), 0);
    if (we) begin
      qs = (id == 0) ? exp_wa.size() : exp_wb.size();
      chk(id == 0 ? "we_expected_a" : "we_expected_b", int'(qs > 0), 1);
      if (qs > 0) begin
        if (id == 0) e = exp_wa.pop_front(); else e = exp_wb.pop_front();
        chk(id == 0 ? "we_addr_a" : "we_addr_b", int'(addr), e >> 8);
        chk(id == 0 ? "we_data_a" : "we_data_b", int'(wd), e & 255);
      end
    end
    if (re) begin
      qs = (id == 0) ? exp_ra.size() : exp_rb.size();
      chk(id == 0 ? "re_expected_a" : "re_expected_b", int'(qs > 0), 1);
      if (qs > 0) begin
        if (id == 0) e = exp_ra.pop_front(); else e = exp_rb.pop_front();
        chk(id == 0 ? "re_addr_a" : "re_addr_b", int'(addr), e);
      end
    end
    if (oe) chk(id == 0 ? "oe_window_a" : "oe_window_b", int'(allow), 1);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      cmp_side(0, we_a, re_a, oe_a, addr_a, wd_a, allow_a);
      cmp_side(1, we_b, re_b, oe_b, addr_b, wd_b, allow_b);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic low_mid();
    tick(T_Q);
    if (clear_allow) begin
      allow_a = 1'b0;
      allow_b = 1'b0;
      clear_allow = 1'b0;
    end
  endtask

  task automatic send_bit(input bit b, input bit glitch, output bit s);
    low_mid();
    sda_m = b;
    if (glitch) begin
      tick(3); scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(T_Q - 4);
    end else begin
      tick(T_Q);
    end
    scl_m = 1'b1;
    tick(T_Q);
    s = sda_bus;
    tick(T_Q);
    scl_m = 1'b0;
  endtask

  task automatic do_start();
    if (!scl_m) begin
      low_mid(); sda_m = 1'b1; tick(T_Q); scl_m = 1'b1; tick(T_Q);
    end
    sda_m = 1'b0; tick(T_Q); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    low_mid(); sda_m = 1'b0; tick(T_Q); scl_m = 1'b1; tick(T_Q); sda_m = 1'b1; tick(4 * T_Q);
  endtask

  function automatic int dec(input logic [7:0] b);
    if (b[7:1] == 7'h5A) return 0;
    if (b[7:1] == 7'h3C) return 1;
    return -1;
  endfunction

  task automatic read_push(input int id);
    rdq.push_back(mdl[id][ptr[id]]);
    if (id == 0) exp_ra.push_back(ptr[id]); else exp_rb.push_back(ptr[id]);
    if (ainc[id]) ptr[id] = (ptr[id] + 1) % 256;
  endtask

  task automatic send_byte(input logic [7:0] b, input int id, input int gl_bit,
                           input bit keep, output bit acked);
    bit s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == gl_bit, s);
    if (id == 0) allow_a = 1'b1;
    else if (id == 1) allow_b = 1'b1;
    send_bit(1'b1, 1'b0, s);
    acked = !s;
    if (acked) ack_cnt++;
    if (!keep) clear_allow = 1'b1;
  endtask

  task automatic tx_addr(input logic [7:0] ab);
    int id;
    bit a;
    id = dec(ab);
    if (id >= 0 && ab[0]) read_push(id);
    send_byte(ab, id, -1, id >= 0 && ab[0], a);
    chk("addr_ack", int'(a), int'(id >= 0));
    cur = id;
    if (id == 0) chk("busy_after_match_a", int'(busy_a), 1);
    else if (id == 1) chk("busy_after_match_b", int'(busy_b), 1);
    else begin
      chk("busy_after_miss_a", int'(busy_a), 0);
      chk("busy_after_miss_b", int'(busy_b), 0);
    end
  endtask

  task automatic wr_ptr(input logic [7:0] p);
    bit a;
    ptr[cur] = p;
    send_byte(p, cur, -1, 1'b0, a);
    chk("ptr_ack", int'(a), 1);
  endtask

  task automatic wr_data(input logic [7:0] d, input int gl);
    bit a;
    if (cur == 0) exp_wa.push_back((ptr[0] << 8) | d);
    else exp_wb.push_back((ptr[1] << 8) | d);
    mdl[cur][ptr[cur]] = d;
    if (ainc[cur]) ptr[cur] = (ptr[cur] + 1) % 256;
    send_byte(d, cur, gl, 1'b0, a);
    chk("data_ack", int'(a), 1);
  endtask

  task automatic recv_byte(input bit more, output logic [7:0] v);
    bit s;
    logic [7:0] e;
    chk("rd_pending", int'(rdq.size() > 0), 1);
    e = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      v[i] = s;
    end
    chk("rd_data", int'(v), int'(e));
    clear_allow = 1'b1;
    if (more) read_push(cur);
    send_bit(!more, 1'b0, s);
    if (more) begin
      if (cur == 0) allow_a = 1'b1; else allow_b = 1'b1;
    end else begin
      tick(T_Q);
      chk("nack_busy", int'(cur == 0 ? busy_a : busy_b), 0);
      chk("nack_oe", int'(cur == 0 ? oe_a : oe_b), 0);
    end
  endtask

  task automatic flush_model();
    exp_wa.delete(); exp_wb.delete(); exp_ra.delete(); exp_rb.delete(); rdq.delete();
    cur = -1;
  endtask

  task automatic end_txn();
    do_stop();
    chk("idle_busy_a", int'(busy_a), 0);
    chk("idle_busy_b", int'(busy_b), 0);
    chk("idle_oe_a", int'(oe_a), 0);
    chk("idle_oe_b", int'(oe_b), 0);
    chk("ptr_a", int'(addr_a), ptr[0]);
    chk("ptr_b", int'(addr_b), ptr[1]);
    chk("pending_a", exp_wa.size() + exp_ra.size(), 0);
    chk("pending_b", exp_wb.size() + exp_rb.size(), 0);
    flush_model();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      mdl[0][i] = init_val(i, 0);
      mdl[1][i] = init_val(i, 1);
    end
    ptr[0] = 0;
    ptr[1] = 0;
    flush_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v0, v1, ab, bt;
    bit s;
    int kind, id, n;

    model_reset();
    tick(5);
    chk("rst_oe", int'(oe_a), 0);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_wdata", int'(wd_a), 0);
    chk("rst_we_re", int'({we_a, re_a}), 0);
    chk("rst_busy", int'(busy_a), 0);
    rstn = 1'b1;
    tick(4 * T_Q);

    // Write burst with auto-increment.
    do_start(); ack_cnt = 0;
    tx_addr(8'hB4); wr_ptr(8'h10); wr_data(8'hA5, -1); wr_data(8'h3C, -1);
    end_txn();
    chk("burst_acks", ack_cnt, 4);
    chk("burst_final_addr", int'(addr_a), 8'h12);
    chk("burst_reg10", int'(regs_a[8'h10]), 8'hA5);
    chk("burst_reg11", int'(regs_a[8'h11]), 8'h3C);

    // Pointer write, repeated START, two-byte read ending in NACK.
    do_start(); tx_addr(8'hB4); wr_ptr(8'h20);
    do_start(); tx_addr(8'hB5);
    recv_byte(1'b1, v0); recv_byte(1'b0, v1);
    end_txn();
    chk("read_byte0", int'(v0), 8'h5A);
    chk("read_byte1", int'(v1), 8'hC3);
    chk("read_final_addr", int'(addr_a), 8'h22);

    // Address mismatch and general call.
    do_start(); ack_cnt = 0; tx_addr(8'hA0); end_txn();
    do_start(); tx_addr(8'h00); end_txn();
    chk("miss_acks", ack_cnt, 0);

    // Pointer wrap, then the non-incrementing target.
    do_start(); tx_addr(8'hB4); wr_ptr(8'hFF); wr_data(8'h11, -1); wr_data(8'h22, -1); end_txn();
    chk("wrap_addr", int'(addr_a), 8'h01);
    chk("wrap_regFF", int'(regs_a[8'hFF]), 8'h11);
    chk("wrap_reg00", int'(regs_a[8'h00]), 8'h22);
    do_start(); tx_addr(8'h78); wr_ptr(8'hFF); wr_data(8'h55, -1); wr_data(8'h66, -1); end_txn();
    chk("noinc_addr", int'(addr_b), 8'hFF);
    chk("noinc_regFF", int'(regs_b[8'hFF]), 8'h66);

    // SCL glitch inside a data bit, then STOP half way through a data byte.
    do_start(); tx_addr(8'hB4); wr_ptr(8'h40); wr_data(8'h96, 3); end_txn();
    chk("glitch_reg40", int'(regs_a[8'h40]), 8'h96);
    do_start(); tx_addr(8'hB4); wr_ptr(8'h50);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, s);
    end_txn();
    chk("abort_reg50", int'(regs_a[8'h50]), int'(init_val(8'h50, 0)));

    // Asynchronous reset while the target is pulling SDA low for an ACK.
    do_start(); bt = 8'hB4;
    for (int i = 7; i >= 0; i--) send_bit(bt[i], 1'b0, s);
    allow_a = 1'b1;
    low_mid();
    sda_m = 1'b1;
    for (int i = 0; i < 16 && !oe_a; i++) tick(1);
    chk("ack_before_reset", int'(oe_a), 1);
    @(posedge clk); #3; rstn = 1'b0; #1;
    chk("arst_oe", int'(oe_a), 0);
    chk("arst_sda_bus", int'(sda_bus), 1);
    chk("arst_busy", int'(busy_a), 0);
    chk("arst_addr", int'(addr_a), 0);
    chk("arst_wdata", int'(wd_a), 0);
    chk("arst_we_re", int'({we_a, re_a}), 0);
    model_reset();
    allow_a = 1'b0; clear_allow = 1'b0;
    tick(4); scl_m = 1'b1; tick(8); rstn = 1'b1; tick(4 * T_Q);

    // Randomised traffic against the model.
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      id = $urandom_range(0, 1);
      ab = (id == 0) ? 8'hB4 : 8'h78;
      n = $urandom_range(1, 3);
      do_start();
      case (kind)
        0: begin
          tx_addr(ab); wr_ptr(8'($urandom));
          for (int k = 0; k <= n; k++) wr_data(8'($urandom), -1);
        end
        1: begin
          tx_addr(ab); wr_ptr(8'($urandom));
          do_start(); tx_addr(ab | 8'h01);
          for (int k = 0; k < n; k++) recv_byte(k != n - 1, v0);
        end
        2: begin
          tx_addr(ab | 8'h01);
          for (int k = 0; k < n; k++) recv_byte(k != n - 1, v0);
        end
        default: begin
          ab = 8'($urandom);
          if (dec(ab) >= 0) ab = 8'hA2;
          tx_addr(ab);
        end
      endcase
      end_txn();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regmap.md
Name: i2c_slave_regmap

Overview:
- Next-generation I2C target that is fully synchronous to a system clock. SCL and SDA are treated as oversampled data inputs, never as clocks.
- Decodes a parametrised 7-bit target address and exposes a byte-wide register-map port.
- Supports pointer auto-increment for multi-byte bursts, repeated START, master ACK/NACK on reads, and a glitch filter.
- Sits between the pad ring (open-drain SDA) and the controller register file.

Parameters:
- SLAVE_ADDR, 7'h5A, 7-bit target address that is ACKed.
- FILTER_LEN, 3, consecutive equal samples required before a filtered SCL/SDA level changes (1..7).
- AUTO_INC, 1, 1 = register pointer increments after each data byte written or read; 0 = pointer holds.

Ports:
- clk  in  1  system clock; must be >= 16x the SCL frequency.
- rstn  in  1  asynchronous active-low reset.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr  out  8  current register pointer.
- reg_wdata  out  8  write data, valid while reg_we.
- reg_we  out  1  one-clk write strobe.
- reg_rdata  in  8  read data for reg_addr; combinational from the register map.
- reg_re  out  1  one-clk strobe when reg_rdata is captured (for read-clear side effects).
- busy  out  1  high from a matched address until STOP or NACK.

Behaviour:
- Reset (async, rstn=0):
  - sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0.
  - State=IDLE; filters preset to 1; shift register=0.
  - Reset mid-transfer releases SDA immediately.
- Input conditioning:
  - 2-FF synchroniser on each line, followed by a FILTER_LEN stable-count filter.
  - Edge detectors run on the filtered levels. Pin-to-event latency is 2+FILTER_LEN clks.
- Bus conditions: START = filtered SDA falls while SCL high. STOP = filtered SDA rises while SCL high.
- Precedence, from any state:
  - STOP -> IDLE with sda_oe=0 and busy=0.
  - START -> ADDR with the bit counter cleared. This covers repeated START.
  - START and STOP take precedence over bit processing in the same clk.
- Bit timing: data is sampled on the SCL rise event. sda_oe is updated only on the SCL fall event.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first.
    - On the fall after bit 8: if byte[7:1]==SLAVE_ADDR -> ACK_ADDR, sda_oe=1, busy=1.
    - Otherwise -> IDLE, no ACK. The general call (0x00) is not ACKed.
  - ACK_ADDR: on the next fall, release SDA.
    - R/W=0 -> WR_PTR.
    - R/W=1 -> RD_DATA: capture reg_rdata into the shift register, pulse reg_re, drive bit 7 (sda_oe = ~bit).
  - WR_PTR: shift 8 bits. On the fall after bit 8: reg_addr<=byte, sda_oe=1 -> ACK_PTR.
  - ACK_PTR: next fall releases SDA -> WR_DATA.
  - WR_DATA: shift 8 bits. On the fall after bit 8:
    - reg_wdata<=byte; reg_we=1 for exactly one clk; sda_oe=1 -> ACK_WR.
    - If AUTO_INC, reg_addr increments by 1 on the following clk, wrapping 0xFF->0x00.
  - ACK_WR: next fall releases SDA -> WR_DATA.
  - RD_DATA: drive bits 6..0 on successive falls. After bit 0, the following fall releases SDA -> RD_ACK.
    - If AUTO_INC, reg_addr increments (wrapping) on the clk after the reg_re capture.
  - RD_ACK: sample SDA on the SCL rise.
    - 0 (ACK) -> on the next fall capture reg_rdata, pulse reg_re, drive bit 7 -> RD_DATA.
    - 1 (NACK) -> WAIT_STOP, busy=0, sda_oe=0.
  - WAIT_STOP: ignore bits until START or STOP.
- Pointer retention: reg_addr persists across STOP and repeated START, so write-pointer / Sr / read works.
- Strobe rules:
  - reg_we and reg_re never assert in the same clk.
  - A START/STOP arriving mid-byte discards the partial byte with no strobe.

Test Plan:
- Write burst: START, 0xB4, ptr 0x10, data 0xA5, 0x3C, STOP -> 4 ACKs; reg_we twice with (0x10,0xA5) then (0x11,0x3C); final reg_addr=0x12; busy returns to 0.
- Combined read: START, 0xB4, 0x20, Sr, 0xB5, read 2 bytes (ACK, NACK) with regmap returning 0x5A@0x20 and 0xC3@0x21 -> SDA shows 0x5A, 0xC3; reg_re twice; WAIT_STOP entered; sda_oe=0 afterwards.
- Address mismatch: START, 0xA0 -> no ACK (sda_oe stays 0), no strobes, IDLE, busy=0.
- Wrap and AUTO_INC=0: ptr 0xFF, write 2 bytes -> writes at 0xFF then 0x00; rerun with AUTO_INC=0 -> both writes to 0xFF.
- Glitch and abort: 1-clk SCL pulse during a data bit -> no bit shifted. STOP after 4 bits of a write byte -> no reg_we, IDLE.
- Async reset with SDA held low during ACK -> sda_oe=0 within the same clk edge; all outputs at their reset values.
